// File: rtl/lfsr_rand_arbiter.sv
// Round-robin arbiter sharing one external XNOR LFSR between requesters.
// Draws are masked rejection samples mapped into [0, range) with a bounded-retry fallback.
module lfsr_rand_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_BITS   = 11,
  parameter int OUT_BITS   = 6,
  parameter int STEPS      = 4,
  parameter int MAX_TRIES  = 3,
  parameter int RESET_SEED = 0
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_n,
  input  logic [NUM_REQ-1:0]           i_Req,
  input  logic [NUM_REQ*OUT_BITS-1:0]  i_Range,
  input  logic                         i_Seed_Req,
  input  logic [NUM_BITS-1:0]          i_Seed_Value,
  input  logic [NUM_BITS-1:0]          i_LFSR_Data,
  output logic                         o_LFSR_Enable,
  output logic                         o_LFSR_Seed_DV,
  output logic [NUM_BITS-1:0]          o_LFSR_Seed_Data,
  output logic [NUM_REQ-1:0]           o_Gnt,
  output logic                         o_Valid,
  output logic [OUT_BITS-1:0]          o_Rand
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
  localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_STEP,
    S_CHECK,
    S_DELIVER
  } state_t;

  state_t                state, state_n;
  logic [IDX_W-1:0]      ptr, ptr_n;
  logic [IDX_W-1:0]      gidx, gidx_n;
  logic [NUM_REQ-1:0]    gnt_n;
  logic [OUT_BITS-1:0]   range_r, range_n;
  logic [OUT_BITS-1:0]   mask_r, mask_n;
  logic [TRY_W-1:0]      tries, tries_n;
  logic [STEP_W-1:0]     step_cnt, step_n;
  logic [OUT_BITS-1:0]   result_n;
  logic                  seed_pend, seed_pend_n;
  logic [NUM_BITS-1:0]   seed_val, seed_val_n;

  logic                  found;
  logic [IDX_W-1:0]      sel_idx;
  logic [OUT_BITS-1:0]   sel_range;
  logic [OUT_BITS-1:0]   cand;
  int unsigned           k;

  generate
    if (NUM_BITS > OUT_BITS) begin : g_hi
      logic unused_lfsr_hi;
      assign unused_lfsr_hi = ^i_LFSR_Data[NUM_BITS-1:OUT_BITS];
    end
  endgenerate

  // First set request at or after the pointer, wrapping around.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    k       = 0;
    for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
      k = unsigned'(32'(ptr)) + i;
      if (k >= unsigned'(NUM_REQ)) k = k - unsigned'(NUM_REQ);
      if (!found && i_Req[k[IDX_W-1:0]]) begin
        found   = 1'b1;
        sel_idx = k[IDX_W-1:0];
      end
    end
  end

  assign sel_range = i_Range[sel_idx*OUT_BITS +: OUT_BITS];
  assign cand      = i_LFSR_Data[OUT_BITS-1:0] & mask_r;

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    gidx_n      = gidx;
    gnt_n       = o_Gnt;
    range_n     = range_r;
    mask_n      = mask_r;
    tries_n     = tries;
    step_n      = step_cnt;
    result_n    = o_Rand;
    seed_pend_n = seed_pend;
    seed_val_n  = seed_val;

    case (state)
      S_IDLE: begin
        if (seed_pend) begin
          state_n = S_SEED;
        end else if (found) begin
          gidx_n         = sel_idx;
          gnt_n          = '0;
          gnt_n[sel_idx] = 1'b1;
          range_n        = (sel_range == '0) ? OUT_BITS'(1) : sel_range;
          // Smear R-1 rightwards to get the smallest 2^k-1 covering it.
          mask_n         = range_n - OUT_BITS'(1);
          for (int unsigned i = 1; i < unsigned'(OUT_BITS); i++) begin
            mask_n = mask_n | (mask_n >> i);
          end
          tries_n = '0;
          step_n  = '0;
          state_n = S_STEP;
        end
      end
      S_SEED: begin
        seed_pend_n = 1'b0;
        state_n     = S_IDLE;
      end
      S_STEP: begin
        if (step_cnt == STEP_LAST) begin
          step_n  = '0;
          state_n = S_CHECK;
        end else begin
          step_n = step_cnt + STEP_W'(1);
        end
      end
      S_CHECK: begin
        tries_n = tries + TRY_W'(1);
        if (cand < range_r) begin
          result_n = cand;
          state_n  = S_DELIVER;
        end else if (tries_n == TRY_LAST) begin
          result_n = cand - range_r;
          state_n  = S_DELIVER;
        end else begin
          state_n = S_STEP;
        end
      end
      S_DELIVER: begin
        ptr_n   = (gidx == IDX_LAST) ? '0 : gidx + IDX_W'(1);
        gnt_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // A new seed request overrides the clear in SEED so it is never lost.
    if (i_Seed_Req) begin
      seed_pend_n = 1'b1;
      seed_val_n  = (&i_Seed_Value) ? '0 : i_Seed_Value;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gidx      <= '0;
      o_Gnt     <= '0;
      range_r   <= '0;
      mask_r    <= '0;
      tries     <= '0;
      step_cnt  <= '0;
      o_Rand    <= '0;
      seed_pend <= 1'b1;
      seed_val  <= NUM_BITS'(RESET_SEED);
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gidx      <= gidx_n;
      o_Gnt     <= gnt_n;
      range_r   <= range_n;
      mask_r    <= mask_n;
      tries     <= tries_n;
      step_cnt  <= step_n;
      o_Rand    <= result_n;
      seed_pend <= seed_pend_n;
      seed_val  <= seed_val_n;
    end
  end

  assign o_LFSR_Enable    = (state == S_SEED) || (state == S_STEP);
  assign o_LFSR_Seed_DV   = (state == S_SEED);
  assign o_LFSR_Seed_Data = (state == S_SEED) ? seed_val : '0;
  assign o_Valid          = (state == S_DELIVER);

endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
Round-robin controller that shares one LFSR instance (NUM_BITS-wide, XNOR feedback, seed loads only when enable and seed-valid are both high) between NUM_REQ game-logic requesters, e.g. spawn-position and spawn-timer generators.
- Sequences the LFSR's enable and seed inputs.
- Advances the LFSR STEPS times per draw to decorrelate consecutive draws.
- Maps the LFSR value into each requester's range [0, range) by masked rejection sampling, with a bounded-retry fallback.

Parameters:
NUM_REQ, 4, number of requesters
NUM_BITS, 11, LFSR width; must match the LFSR instance
OUT_BITS, 6, width of range and result; OUT_BITS <= NUM_BITS
STEPS, 4, LFSR shifts per draw attempt (>= 1)
MAX_TRIES, 3, draw attempts before fallback (>= 1)
RESET_SEED, 0, seed loaded after reset

Ports:
i_Clk  in  1  clock
i_Rst_n  in  1  synchronous active-low reset
i_Req  in  NUM_REQ  level request per requester; held high until served
i_Range  in  NUM_REQ*OUT_BITS  per-requester range; requester k uses bits [k*OUT_BITS +: OUT_BITS]
i_Seed_Req  in  1  one-cycle pulse requesting a reseed
i_Seed_Value  in  NUM_BITS  seed, sampled on i_Seed_Req
i_LFSR_Data  in  NUM_BITS  LFSR current value
o_LFSR_Enable  out  1  LFSR enable
o_LFSR_Seed_DV  out  1  LFSR seed-valid
o_LFSR_Seed_Data  out  NUM_BITS  LFSR seed data
o_Gnt  out  NUM_REQ  one-hot grant; held from grant through delivery
o_Valid  out  1  one-cycle result strobe
o_Rand  out  OUT_BITS  result; valid when o_Valid = 1

Behaviour:
- Reset (i_Rst_n low at a clock edge) forces:
  - o_Gnt=0, o_Valid=0, o_Rand=0, o_LFSR_Enable=0, o_LFSR_Seed_DV=0.
  - RR pointer=0, seed-pending=1 with pending value RESET_SEED.
  - State=IDLE. Reset mid-draw aborts the draw with no o_Valid.
- Seed capture: i_Seed_Req in any state latches i_Seed_Value and sets seed-pending. A later pulse overwrites an unserved value.
  - All-ones lockup guard: an all-ones seed is replaced by 0.
- State machine IDLE, SEED, STEP, CHECK, DELIVER:
- IDLE:
  - If seed-pending: go to SEED. Seed has priority over requests.
  - Else if any i_Req bit is set: grant the first set bit at or after the RR pointer, wrapping modulo NUM_REQ.
    - Latch that requester's range as R; R=0 is treated as 1.
    - Compute mask M = smallest 2^k-1 >= R-1.
    - Clear tries and the step counter, assert o_Gnt, go to STEP.
- SEED: one cycle with o_LFSR_Enable=1, o_LFSR_Seed_DV=1 and o_LFSR_Seed_Data = pending value. Clear seed-pending, go to IDLE.
- STEP: o_LFSR_Enable=1 for exactly STEPS consecutive cycles, then go to CHECK.
- CHECK: one cycle, o_LFSR_Enable=0, LFSR value stable.
  - cand = i_LFSR_Data[OUT_BITS-1:0] & M; tries increments.
  - If cand < R: result = cand.
  - Else if tries == MAX_TRIES: result = cand - R. This is always < R because M < 2R.
  - Else: back to STEP for another STEPS shifts.
- DELIVER: one cycle with o_Valid=1, o_Rand=result, o_Gnt held. Then RR pointer = granted index + 1 (mod NUM_REQ), o_Gnt=0, go to IDLE.
- Latency: from the edge that grants to the o_Valid cycle is STEPS+2 cycles for a first-try accept. Each retry adds STEPS+1 cycles.
- o_Rand holds its value between strobes.
- Request dropped mid-draw: the draw completes and o_Valid still fires.
- A requester must see o_Valid with its own o_Gnt bit set before it drops i_Req or issues a new request.
- o_LFSR_Seed_DV is never high without o_LFSR_Enable. o_LFSR_Seed_Data = 0 outside SEED.
- Outside SEED and STEP, o_LFSR_Enable=0, so the LFSR is frozen.

Test Plan:
- Reset, then i_Req=0001, i_Range[0]=16 (defaults, LFSR seeded 0) -> SEED cycle; LFSR steps 1,3,7,15; o_Valid with o_Gnt=0001 and o_Rand=15 exactly STEPS+2 cycles after grant.
- Reset, i_Req=0001, range 6 -> checks see 7 (reject), 7 (reject), then 2041&7=1 (accept); o_Rand=1 on the third check.
- MAX_TRIES=2, range 6, seed 0 -> two rejects of 7; fallback o_Rand=7-6=1.
- i_Req=1111 held, all ranges 16 -> grants in order 0001, 0010, 0100, 1000, 0001; never two o_Gnt bits set at once.
- i_Seed_Req with i_Seed_Value=2047 during STEP -> current draw completes; next IDLE enters SEED with o_LFSR_Seed_Data=0 (lockup guard) before any new grant.
- i_Rst_n low mid-STEP -> next cycle all outputs 0, no o_Valid; SEED of RESET_SEED occurs before the next grant.
